// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified instruction/data memory path: bus widths,
// arbiter state encoding, transaction-owner encoding and grant-vector bit positions.
package mips_mem_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t DONE   = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  // Bit positions inside the one-hot grant vector from mem_arb_pick
  localparam int unsigned GNT_IF = 0;
  localparam int unsigned GNT_DM = 1;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bundles the fetch requester, data requester and memory-array signals of the
// unified memory arbiter. slave = arbiter side, master = pipeline/memory side.
interface unified_mem_arbiter_if
  import mips_mem_pkg::*;
#(
  parameter int unsigned AW = ADDR_W,
  parameter int unsigned DW = DATA_W
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic [DW-1:0] if_rdata;
  logic          if_valid;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic [DW-1:0] dm_rdata;
  logic          dm_valid;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rdata, if_valid, dm_gnt, dm_rdata, dm_valid,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rdata, if_valid, dm_gnt, dm_rdata, dm_valid,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Priority pick between fetch and data requesters. Data wins unless the
// starvation limit has been hit, in which case a contending fetch wins.
module mem_arb_pick
  import mips_mem_pkg::*;
(
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       starve_hit,
  output logic [1:0] gnt
);

  // One-hot pick; zero when nobody requests
  always_comb begin
    gnt = '0;
    if (if_req && (starve_hit || !dm_req)) begin
      gnt[GNT_IF] = 1'b1;
    end else if (dm_req) begin
      gnt[GNT_DM] = 1'b1;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port 64x32 memory between instruction fetch and the
// MEM-stage load/store port. One transaction at a time: IDLE grants, ACCESS
// drives the array for MEM_LAT cycles, DONE pulses the owner's valid.
// Optional fetch anti-starvation: define UNIFIED_MEM_ARB_FAIRNESS_EN.
module unified_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input logic                  clk,
  input logic                  rst,
  unified_mem_arbiter_if.slave bus
);

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
    $error("unified_mem_arbiter: MEM_LAT and STARVE_MAX must be within 1..15");
  end

  state_t              state_q;
  logic [3:0]          lat_cnt_q;
  logic                owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   dm_rdata_q;
  logic [1:0]          pick;
  logic                starve_hit;
  logic                idle;
  logic                last_access;

  assign idle        = (state_q == IDLE);
  assign last_access = (state_q == ACCESS) && (lat_cnt_q == 4'd0);

  mem_arb_pick u_pick (
    .if_req     (bus.if_req),
    .dm_req     (bus.dm_req),
    .starve_hit (starve_hit),
    .gnt        (pick)
  );

  assign bus.if_gnt = idle & pick[GNT_IF];
  assign bus.dm_gnt = idle & pick[GNT_DM];

`ifdef UNIFIED_MEM_ARB_FAIRNESS_EN
  logic [3:0] starve_q;

  // Count data grants taken while fetch waits; a fetch grant or an idle
  // cycle without fetch demand forgives the history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= 4'd0;
    end else if (bus.if_gnt || (idle && !bus.if_req)) begin
      starve_q <= 4'd0;
    end else if (bus.dm_gnt && bus.if_req) begin
      starve_q <= starve_q + 4'd1;
    end
  end

  assign starve_hit = (starve_q == 4'(STARVE_MAX));
`else
  assign starve_hit = 1'b0;
`endif

  // Transaction sequencer: latch the winner's request, count down, finish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lat_cnt_q <= 4'd0;
      owner_q   <= OWN_IF;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.dm_gnt || bus.if_gnt) begin
            state_q   <= ACCESS;
            lat_cnt_q <= LAT_INIT;
            owner_q   <= bus.dm_gnt ? OWN_DM : OWN_IF;
            we_q      <= bus.dm_gnt & bus.dm_we;
            addr_q    <= bus.dm_gnt ? bus.dm_addr : bus.if_addr;
            wdata_q   <= bus.dm_gnt ? bus.dm_wdata : '0;
          end
        end
        ACCESS: begin
          if (lat_cnt_q == 4'd0) begin
            state_q <= DONE;
          end else begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data is only valid on the final access cycle; stores leave rdata alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else if (last_access && !we_q) begin
      if (owner_q == OWN_DM) begin
        dm_rdata_q <= bus.mem_rdata;
      end else begin
        if_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en    = (state_q == ACCESS);
  assign bus.mem_we    = last_access && (owner_q == OWN_DM) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_valid  = (state_q == DONE) && (owner_q == OWN_IF);
  assign bus.dm_valid  = (state_q == DONE) && (owner_q == OWN_DM);

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-port 64x32 unified memory between the pipeline's instruction-fetch (IF) requester and its data-memory (MEM-stage LW/SW) requester. Uses a req/gnt/valid handshake and models a multi-cycle memory. The pipeline uses the valid pulses as stall-release points. It sits between the IF/MEM stages and the memory array, replacing the separate instruction and data memories.

Parameters:
ADDR_W, 6, word-address width (64 words)
DATA_W, 32, data width
MEM_LAT, 2, memory access cycles per transaction, legal range 1..15
STARVE_MAX, 3, consecutive data grants allowed while fetch is pending (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch word address
if_gnt  out  1  fetch accepted (combinational, IDLE only)
if_rdata  out  DATA_W  fetched instruction
if_valid  out  1  one-cycle pulse, if_rdata valid
dm_req  in  1  data request; held until dm_gnt
dm_we  in  1  1 = SW, 0 = LW
dm_addr  in  ADDR_W  data word address
dm_wdata  in  DATA_W  store data
dm_gnt  out  1  data accepted (combinational, IDLE only)
dm_rdata  out  DATA_W  load data
dm_valid  out  1  one-cycle pulse, dm_rdata valid; also pulses on store completion
mem_en  out  1  memory access active
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid on last ACCESS cycle

Behaviour:
- FSM states: IDLE, ACCESS, DONE. Encoding comes from the package.
- IDLE:
  - If dm_req, assert dm_gnt. Otherwise, if if_req, assert if_gnt. At most one gnt per cycle.
  - On a grant edge, latch owner, addr, we, wdata; load lat_cnt = MEM_LAT-1; go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - mem_en=1; mem_addr and mem_wdata come from the latches and are held stable.
  - mem_we=1 only when owner is data, we=1, and lat_cnt==0.
  - Decrement lat_cnt each cycle.
  - At lat_cnt==0: capture mem_rdata into the owner's rdata register (skip for stores) and go to DONE.
- DONE:
  - Owner's valid=1 for exactly one cycle; no grants; go to IDLE.
  - rdata registers hold their value until the next capture.
- Latency:
  - Grant to valid = MEM_LAT+1 cycles.
  - Minimum request-to-request spacing = MEM_LAT+2 cycles.
  - Example, MEM_LAT=2: gnt at cycle 0, ACCESS at 1–2, valid at 3, next gnt possible at 4.
- Simultaneous if_req and dm_req in IDLE: data wins. Fetch keeps if_req high and is served in the next IDLE.
- Requests arriving in ACCESS or DONE get no gnt; they are sampled at the next IDLE.
- lat_cnt width is 4 bits; no wrap, since it only counts down from MEM_LAT-1 to 0.
- Reset values (asynchronous, also mid-transaction):
  - state=IDLE, lat_cnt=0.
  - All gnt, valid, mem_en, mem_we = 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
  - An in-flight store whose final ACCESS cycle has not been reached is not written. mem_we drops immediately with reset.
- Requests must not be dropped before their gnt; behaviour if a requester does is undefined.

Optional Feature:
- Macro: UNIFIED_MEM_ARB_FAIRNESS_EN.
- Defined:
  - A 2-bit-or-wider starve counter increments on each data grant given while if_req=1.
  - It clears on any fetch grant and whenever IDLE is reached with if_req=0.
  - When starve == STARVE_MAX, a contending fetch wins over data.
- Undefined: strict data priority; no counter is instantiated.

Decomposition:
- Shared package mips_mem_pkg holds:
  - State enum: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
  - Owner encoding: OWN_IF=1'b0, OWN_DM=1'b1.
  - ADDR_W and DATA_W defaults, shared with the memory model.
- One natural combinational sub-module, mem_arb_pick. Inputs: if_req, dm_req, the starve condition. Outputs: a one-hot grant. It keeps the priority/fairness rule isolated and unit-testable.

Test Plan:
- Single LW: dm_req=1, dm_we=0, dm_addr=5, mem[5]=0xDEADBEEF, MEM_LAT=2 → dm_gnt at cycle 0, mem_en cycles 1–2 with mem_addr=5, dm_valid at cycle 3 with dm_rdata=0xDEADBEEF, if_valid never.
- Single SW: dm_we=1, dm_addr=9, dm_wdata=0x12345678 → mem_we high only at cycle 2, dm_valid at cycle 3, a later LW of addr 9 returns 0x12345678.
- Contention: if_req(addr 0) and dm_req(addr 3) both high at cycle 0 → dm_gnt at 0, dm_valid at 3, if_gnt at 4, if_valid at 7.
- Back-to-back fetches: if_req held, addresses 0, 1, 2 → if_gnt at 0, 4, 8; if_valid at 3, 7, 11; rdata matches mem.
- Reset mid-store: SW to addr 7 granted, rst asserted in the first ACCESS cycle (MEM_LAT=2) → mem_we never high, mem[7] unchanged, all outputs 0, state IDLE after release.
- Fairness (macro on, STARVE_MAX=3): if_req and dm_req held continuously → grant order DM, DM, DM, IF, DM, DM, DM, IF; with macro off, IF is never granted.
